// File: rtl/fp32_pkg.sv
// FP32 field helpers, constants and FSM state encoding shared by the
// accumulator and future FP adder stages.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = FRAC_W + 1;
    localparam int BIAS   = 127;

    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [30:0] FP_MAX_MAG = {8'hFE, 23'h7F_FFFF};

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    // Unpacked operand: sign, biased exponent, 24-bit mantissa with hidden bit.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_op_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    // exp==0 means zero here: denormals are not supported, so frac is ignored.
    function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] x);
        return (x[30:23] == 8'h00) ? 24'h00_0000 : {1'b1, x[22:0]};
    endfunction

    function automatic fp_op_t fp_unpack(input logic [31:0] x);
        fp_op_t op;
        op.sign = fp_sign(x);
        op.exp  = fp_exp(x);
        op.man  = fp_man(x);
        return op;
    endfunction

endpackage

// File: rtl/fp_acc_stream_if.sv
// Term-in / sum-out handshake bundle of the FP32 accumulator.
interface fp_acc_stream_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;

    // Producer of terms and consumer of results.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/fp_lzc.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module fp_lzc (
    input  logic [23:0] val_i,
    output logic [4:0]  lz_o
);
    // Scan upward so the most significant set bit has the final say.
    always_comb begin
        lz_o = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (val_i[i]) lz_o = 5'(23 - i);
        end
    end
endmodule

// File: rtl/fp_acc_stream.sv
// Streaming FP32 accumulator: sums terms until one is flagged last, then
// offers the total with valid/ready. Each term takes ALIGN/ADD/NORM cycles;
// arithmetic truncates and saturates to max finite on overflow.
module fp_acc_stream
    import fp32_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    fp_acc_stream_if.slave bus
);

    state_t           state_q, state_d;
    logic             rdy_en_q;
    logic [31:0]      term_q;
    logic             last_q;
    logic [31:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;

    // ALIGN -> ADD pipeline registers
    fp_op_t           a_q;
    logic             sign_b_q;
    logic [23:0]      man_b_q;
    // ADD -> NORM
    logic [24:0]      sum_q;

    logic             accept;
    logic             out_fire;

    assign accept   = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    // ---------------- ALIGN: order operands and shift the smaller ----------
    fp_op_t      op_acc, op_trm, op_a, op_b;
    logic [7:0]  exp_diff;
    logic [23:0] man_b_sh;

    // Larger exponent (then larger mantissa) becomes A; B is shifted to match.
    always_comb begin
        op_acc = fp_unpack(acc_q);
        op_trm = fp_unpack(term_q);
        if ((op_acc.exp > op_trm.exp) ||
            ((op_acc.exp == op_trm.exp) && (op_acc.man >= op_trm.man))) begin
            op_a = op_acc;
            op_b = op_trm;
        end else begin
            op_a = op_trm;
            op_b = op_acc;
        end
        exp_diff = op_a.exp - op_b.exp;
        man_b_sh = (exp_diff >= 8'd25) ? 24'h00_0000 : (op_b.man >> exp_diff);
    end

    // ---------------- ADD: magnitude add or subtract ------------------------
    logic [24:0] sum_d;

    // A >= B in magnitude, so subtraction never wraps and A's sign wins.
    always_comb begin
        if (a_q.sign == sign_b_q) sum_d = {1'b0, a_q.man} + {1'b0, man_b_q};
        else                      sum_d = {1'b0, a_q.man} - {1'b0, man_b_q};
    end

    // ---------------- NORM: renormalize, clamp, repack ----------------------
    logic [4:0]        lz;
    logic signed [9:0] exp_n;
    logic [23:0]       man_n;
    logic [31:0]       norm_res;
    logic              unused_hidden;

    fp_lzc u_lzc (
        .val_i (sum_q[23:0]),
        .lz_o  (lz)
    );

    assign unused_hidden = man_n[23];

    // Underflow flushes to +0; overflow saturates to the signed max finite.
    always_comb begin
        exp_n    = '0;
        man_n    = '0;
        norm_res = FP_ZERO;
        if (sum_q != 25'd0) begin
            if (sum_q[24]) begin
                man_n = sum_q[24:1];
                exp_n = $signed({2'b00, a_q.exp}) + 10'sd1;
            end else begin
                man_n = sum_q[23:0] << lz;
                exp_n = $signed({2'b00, a_q.exp}) - $signed({5'b00000, lz});
            end
            if (exp_n <= 10'sd0)        norm_res = FP_ZERO;
            else if (exp_n >= 10'sd255) norm_res = {a_q.sign, FP_MAX_MAG};
            else                        norm_res = {a_q.sign, exp_n[7:0], man_n[22:0]};
        end
    end

    // ---------------- FSM ---------------------------------------------------
    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: one term per pass, park in DONE until the sum is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = last_q ? DONE : IDLE;
            DONE:    if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: in_ready held low through reset and until the first clock after it.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && rdy_en_q;
        bus.out_valid = (state_q == DONE);
        bus.out_data  = acc_q;
        bus.out_count = cnt_q;
    end

    // Ready enable: goes high on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en_q <= 1'b0;
        else     rdy_en_q <= 1'b1;
    end

    // Datapath registers advance with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_q   <= FP_ZERO;
            last_q   <= 1'b0;
            acc_q    <= FP_ZERO;
            cnt_q    <= '0;
            a_q      <= '0;
            sign_b_q <= 1'b0;
            man_b_q  <= '0;
            sum_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        term_q <= bus.in_data;
                        last_q <= bus.in_last;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
                    end
                end
                ALIGN: begin
                    a_q      <= op_a;
                    sign_b_q <= op_b.sign;
                    man_b_q  <= man_b_sh;
                end
                ADD:  sum_q <= sum_d;
                NORM: acc_q <= norm_res;
                DONE: begin
                    if (out_fire) begin
                        acc_q <= FP_ZERO;
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc_stream.sv
// Self-checking bench for fp_acc_stream: table of sums plus hand-written
// backpressure, counter saturation and mid-sum reset sequences.
module tb_fp_acc_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_acc_stream_if #(.CNT_W(8)) bus();

    fp_acc_stream #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  cnt;
    } res_t;

    typedef struct {
        int          n;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] exp_data;
        logic [7:0]  exp_cnt;
    } vec_t;

    res_t sb[$];
    vec_t vecs[12];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [31:0] d, input logic [7:0] c);
        res_t r;
        r.data = d;
        r.cnt  = c;
        return r;
    endfunction

    // Scoreboard: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        res_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h count %0d, expected no result", bus.out_data, bus.out_count);
            end else begin
                e = sb.pop_front();
                check("result_data", bus.out_data, e.data);
                check("result_count", {24'h0, bus.out_count}, {24'h0, e.cnt});
            end
        end
    end

    // Drive one term and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic last);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready %b, expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w;
        logic bad;

        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'h0, bus.in_ready},  32'h0);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_data",  bus.out_data,           32'h0);
        check("rst_out_count", {24'h0, bus.out_count}, 32'h0);
        rst = 1'b0;
        #1;
        check("release_in_ready_before_edge", {31'h0, bus.in_ready}, 32'h0);
        @(posedge clk); #1;
        check("release_in_ready_after_edge", {31'h0, bus.in_ready}, 32'h1);

        vecs[0]  = '{2, 32'h3F800000, 32'h40000000, 32'h40400000, 8'd2}; // 1+2
        vecs[1]  = '{2, 32'h3FC00000, 32'hBFC00000, 32'h00000000, 8'd2}; // cancel
        vecs[2]  = '{2, 32'h4E800000, 32'h3F800000, 32'h4E800000, 8'd2}; // diff 30
        vecs[3]  = '{2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 8'd2}; // overflow
        vecs[4]  = '{1, 32'h3F800000, 32'h0,        32'h3F800000, 8'd1}; // single
        vecs[5]  = '{1, 32'h00400000, 32'h0,        32'h00000000, 8'd1}; // exp 0
        vecs[6]  = '{1, 32'hC0000000, 32'h0,        32'hC0000000, 8'd1}; // negative
        vecs[7]  = '{2, 32'h3F800000, 32'hBF000000, 32'h3F000000, 8'd2}; // 1-0.5
        vecs[8]  = '{2, 32'h00800001, 32'h80800000, 32'h00000000, 8'd2}; // underflow
        vecs[9]  = '{2, 32'hBF800000, 32'hC0000000, 32'hC0400000, 8'd2}; // -1-2
        vecs[10] = '{2, 32'h3F800000, 32'h33800000, 32'h3F800000, 8'd2}; // diff 24 truncated
        vecs[11] = '{2, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF, 8'd2}; // neg overflow

        for (int i = 0; i < 12; i++) begin
            sb.push_back(mk(vecs[i].exp_data, vecs[i].exp_cnt));
            if (vecs[i].n == 1) begin
                send(vecs[i].t0, 1'b1);
            end else begin
                send(vecs[i].t0, 1'b0);
                send(vecs[i].t1, 1'b1);
            end
            if (i == 0) begin
                lat = 0;
                while (!bus.out_valid && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                check("last_accept_to_valid_cycles", lat, 32'd4);
            end
            wait_drain();
        end

        // Counter saturation: 300 zero terms
        sb.push_back(mk(32'h0, 8'd255));
        for (int k = 0; k < 300; k++) send(32'h0, (k == 299));
        wait_drain();

        // Backpressure: result held, no term accepted
        bus.out_ready = 1'b0;
        sb.push_back(mk(32'h3F800000, 8'd1));
        send(32'h3F800000, 1'b1);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid_seen", {31'h0, bus.out_valid}, 32'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40000000;
        bus.in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
            check("bp_out_data",  bus.out_data,           32'h3F800000);
            check("bp_in_ready",  {31'h0, bus.in_ready},  32'h0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        sb.push_back(mk(32'h3F800000, 8'd1));
        send(32'h3F800000, 1'b1);
        wait_drain();

        // Reset during ADD of the second term aborts the sum
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);  // now in ALIGN
        @(posedge clk); #1;        // now in ADD
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("midrst_out_data",  bus.out_data,           32'h0);
        check("midrst_out_count", {24'h0, bus.out_count}, 32'h0);
        check("midrst_in_ready",  {31'h0, bus.in_ready},  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) bad = 1'b1;
        end
        check("midrst_no_result", {31'h0, bad}, 32'h0);
        @(posedge clk); #1;
        sb.push_back(mk(32'h40000000, 8'd1));
        send(32'h40000000, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
